// File: rtl/stream_to_xors.sv
// -----------------------------------------------------------------------------
// stream_to_xors
//   Collects a raster-ordered stream of XOR bits (pix_w bits per beat) into one
//   blk_h x blk_w block and hands the block downstream on a valid/ready
//   interface.  Block confidence and disparity are captured on the block's
//   first beat.  A single extra assembly buffer lets a finished block wait
//   while the output register is still occupied; the input stalls only then.
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous active-low reset
//   pix_stream_data  one beat of XOR bits (beat k -> bits k*pix_w .. +pix_w-1)
//   pix_stream_valid beat present
//   pix_stream_ready beat can be taken (low while a finished block is held)
//   conf_in/disp_in  block confidence/disparity, taken on beat 0
//   flush            drop the partially assembled (or held) block
//   xors_out         assembled block, bit j = row j/blk_w, column j%blk_w
//   xors_valid       xors_out/conf_out/disp_out hold a complete block
//   xors_ready       downstream takes the block
//   conf_out         confidence of the presented block
//   disp_out         disparity of the presented block
//   blk_count        blocks accepted downstream, modulo 2^16
// -----------------------------------------------------------------------------
module stream_to_xors #(
   parameter int unsigned blk_w = 16,
   parameter int unsigned blk_h = 16,
   parameter int unsigned pix_w = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [pix_w-1:0]         pix_stream_data,
   input  logic                     pix_stream_valid,
   output logic                     pix_stream_ready,
   input  logic [7:0]               conf_in,
   input  logic [7:0]               disp_in,
   input  logic                     flush,
   output logic [blk_h*blk_w-1:0]   xors_out,
   output logic                     xors_valid,
   input  logic                     xors_ready,
   output logic [7:0]               conf_out,
   output logic [7:0]               disp_out,
   output logic [15:0]              blk_count
);

   localparam int unsigned BITS = blk_w * blk_h;
   localparam int unsigned N    = BITS / pix_w;
   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_BEAT = CW'(N - 1);

   typedef enum logic {
      ASM_FILL,
      ASM_FULL
   } asm_state_e;

   asm_state_e          state_q,    state_d;
   logic [CW-1:0]       beat_q,     beat_d;
   logic [BITS-1:0]     asm_q,      asm_d;
   logic [7:0]          aconf_q,    aconf_d;
   logic [7:0]          adisp_q,    adisp_d;
   logic [BITS-1:0]     out_q,      out_d;
   logic [7:0]          oconf_q,    oconf_d;
   logic [7:0]          odisp_q,    odisp_d;
   logic                ovalid_q,   ovalid_d;
   logic [15:0]         blk_cnt_q,  blk_cnt_d;

   logic                accept;
   logic                out_free;
   logic                first_beat;
   logic                last_beat;
   logic                load_held;
   logic                load_new;
   logic [31:0]         shift;
   logic [BITS-1:0]     blk_asm;
   logic [7:0]          blk_conf;
   logic [7:0]          blk_disp;

   always_comb begin
      state_d   = state_q;
      beat_d    = beat_q;
      asm_d     = asm_q;
      aconf_d   = aconf_q;
      adisp_d   = adisp_q;
      out_d     = out_q;
      oconf_d   = oconf_q;
      odisp_d   = odisp_q;
      ovalid_d  = ovalid_q;
      blk_cnt_d = blk_cnt_q;

      accept     = pix_stream_valid && (state_q == ASM_FILL) && !flush;
      out_free   = !ovalid_q || xors_ready;
      first_beat = accept && (beat_q == '0);
      last_beat  = accept && (beat_q == LAST_BEAT);

      // Block image including the current beat, so a completing block can go
      // straight to the output register in the same cycle.
      shift    = 32'(beat_q) * pix_w;
      blk_asm  = (asm_q & ~(BITS'({pix_w{1'b1}}) << shift))
               | (BITS'(pix_stream_data) << shift);
      blk_conf = first_beat ? conf_in : aconf_q;
      blk_disp = first_beat ? disp_in : adisp_q;

      if (accept) begin
         asm_d   = blk_asm;
         aconf_d = blk_conf;
         adisp_d = blk_disp;
         beat_d  = last_beat ? '0 : beat_q + 1'b1;
      end
      if (flush) begin
         beat_d = '0;
      end

      unique case (state_q)
         ASM_FILL: if (last_beat && !out_free) state_d = ASM_FULL;
         ASM_FULL: if (flush || xors_ready)    state_d = ASM_FILL;
         default:                              state_d = ASM_FILL;
      endcase

      // A held block moves out when downstream takes the current one; flush
      // discards the held block as well.
      load_held = (state_q == ASM_FULL) && xors_ready && !flush;
      load_new  = last_beat && out_free;

      if (load_held) begin
         out_d    = asm_q;
         oconf_d  = aconf_q;
         odisp_d  = adisp_q;
         ovalid_d = 1'b1;
      end else if (load_new) begin
         out_d    = blk_asm;
         oconf_d  = blk_conf;
         odisp_d  = blk_disp;
         ovalid_d = 1'b1;
      end else if (xors_ready) begin
         ovalid_d = 1'b0;
      end

      if (ovalid_q && xors_ready) begin
         blk_cnt_d = blk_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ASM_FILL;
         beat_q    <= '0;
         asm_q     <= '0;
         aconf_q   <= '0;
         adisp_q   <= '0;
         out_q     <= '0;
         oconf_q   <= '0;
         odisp_q   <= '0;
         ovalid_q  <= 1'b0;
         blk_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         beat_q    <= beat_d;
         asm_q     <= asm_d;
         aconf_q   <= aconf_d;
         adisp_q   <= adisp_d;
         out_q     <= out_d;
         oconf_q   <= oconf_d;
         odisp_q   <= odisp_d;
         ovalid_q  <= ovalid_d;
         blk_cnt_q <= blk_cnt_d;
      end
   end

   assign pix_stream_ready = (state_q == ASM_FILL);
   assign xors_out         = out_q;
   assign xors_valid       = ovalid_q;
   assign conf_out         = oconf_q;
   assign disp_out         = odisp_q;
   assign blk_count        = blk_cnt_q;

endmodule

// File: tb/tb_stream_to_xors.sv
// -----------------------------------------------------------------------------
// tb_stream_to_xors
//   Directed scenarios for stream_to_xors (default parameters) with a
//   block-level reference model that is compared against the DUT on every
//   cycle, plus literal expectations at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_stream_to_xors;

   localparam int unsigned BW   = 16;
   localparam int unsigned BH   = 16;
   localparam int unsigned PW   = 2;
   localparam int unsigned BITS = BW * BH;
   localparam int unsigned N    = BITS / PW;

   logic              clk = 1'b0;
   logic              reset;
   logic [PW-1:0]     pix_stream_data;
   logic              pix_stream_valid;
   logic              pix_stream_ready;
   logic [7:0]        conf_in;
   logic [7:0]        disp_in;
   logic              flush;
   logic [BITS-1:0]   xors_out;
   logic              xors_valid;
   logic              xors_ready;
   logic [7:0]        conf_out;
   logic [7:0]        disp_out;
   logic [15:0]       blk_count;

   always #5 clk = ~clk;

   stream_to_xors #(.blk_w(BW), .blk_h(BH), .pix_w(PW)) dut (
      .clk              (clk),
      .reset            (reset),
      .pix_stream_data  (pix_stream_data),
      .pix_stream_valid (pix_stream_valid),
      .pix_stream_ready (pix_stream_ready),
      .conf_in          (conf_in),
      .disp_in          (disp_in),
      .flush            (flush),
      .xors_out         (xors_out),
      .xors_valid       (xors_valid),
      .xors_ready       (xors_ready),
      .conf_out         (conf_out),
      .disp_out         (disp_out),
      .blk_count        (blk_count)
   );

   // xors_ready source: 2 = random per cycle, otherwise the manual level.
   int   rdy_mode = 3;
   logic rdy_man  = 1'b0;
   logic rdy_rnd  = 1'b0;
   assign xors_ready = (rdy_mode == 2) ? rdy_rnd : rdy_man;
   always @(negedge clk) rdy_rnd = ($urandom_range(99) < 60);

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [BITS-1:0] act,
                        input logic [BITS-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- model
   typedef struct packed {
      logic [BITS-1:0] d;
      logic [7:0]      c;
      logic [7:0]      p;
   } blk_t;

   blk_t            pending[$];
   blk_t            m_out = '0;
   blk_t            c_blk;
   bit              m_valid = 1'b0;
   logic [15:0]     m_count = '0;
   int              m_beats = 0;
   logic [BITS-1:0] m_blk = '0;
   logic [7:0]      m_c = '0;
   logic [7:0]      m_p = '0;
   bit              started = 1'b0;
   int              preset_tok = 0;
   int              seen_tok = 0;
   bit              fire, free, have_c, held;

   always @(posedge clk) begin
      if (preset_tok != seen_tok) begin
         m_count  = 16'hFFFF;
         seen_tok = preset_tok;
      end
      if (!reset) begin
         started = 1'b1;
         m_beats = 0;
         pending.delete();
         m_valid = 1'b0;
         m_out   = '0;
         m_count = '0;
      end else begin
         fire   = m_valid && xors_ready;
         free   = !m_valid || xors_ready;
         have_c = 1'b0;
         held   = (pending.size() != 0);
         if (flush) begin
            m_beats = 0;
            pending.delete();
         end else if (pix_stream_valid && !held) begin
            if (m_beats == 0) begin
               m_c = conf_in;
               m_p = disp_in;
            end
            m_blk = (m_blk & ~(256'd3 << (2 * m_beats)))
                  | (256'(pix_stream_data) << (2 * m_beats));
            m_beats++;
            if (m_beats == N) begin
               c_blk.d = m_blk;
               c_blk.c = m_c;
               c_blk.p = m_p;
               have_c  = 1'b1;
               m_beats = 0;
            end
         end
         if (fire) m_count++;
         if (pending.size() != 0 && xors_ready) begin
            m_out   = pending.pop_front();
            m_valid = 1'b1;
         end else if (have_c) begin
            if (free) begin
               m_out   = c_blk;
               m_valid = 1'b1;
            end else begin
               pending.push_back(c_blk);
            end
         end else if (fire) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         check("m_valid",    256'(xors_valid),       256'(m_valid));
         check("m_ready",    256'(pix_stream_ready), 256'(pending.size() == 0));
         check("m_xors_out", xors_out,               m_out.d);
         check("m_conf",     256'(conf_out),         256'(m_out.c));
         check("m_disp",     256'(disp_out),         256'(m_out.p));
         check("m_count",    256'(blk_count),        256'(m_count));
      end
   end

   // ------------------------------------------------------------- stimulus
   function automatic logic [BITS-1:0] rand_blk();
      logic [BITS-1:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[BITS-33:0], 32'($urandom)};
      return r;
   endfunction

   task automatic send_beats(input logic [BITS-1:0] blk, input logic [7:0] c,
                             input logic [7:0] p, input int nb, input int stall);
      for (int k = 0; k < nb; k++) begin
         bit acc;
         int guard;
         acc   = 1'b0;
         guard = 0;
         while (!acc) begin
            @(negedge clk);
            guard++;
            if (guard > 1000) begin
               n_checks++;
               n_fail++;
               $display("FAIL beat_timeout: beat %0d not accepted, ready=%0b required 1", k, pix_stream_ready);
               return;
            end
            conf_in = 8'($urandom);
            disp_in = 8'($urandom);
            if ($urandom_range(99) < stall) begin
               pix_stream_valid = 1'b0;
               pix_stream_data  = 2'($urandom);
            end else begin
               pix_stream_valid = 1'b1;
               pix_stream_data  = 2'(blk >> (2 * k));
               if (k == 0) begin
                  conf_in = c;
                  disp_in = p;
               end
               acc = pix_stream_ready;
            end
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         pix_stream_valid = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      pix_stream_valid = 1'b0;
      flush = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   logic [BITS-1:0] pat5, ones, blk_a, blk_b, blk_c, blk_d;

   initial begin
      reset = 1'b0;
      pix_stream_valid = 1'b0;
      pix_stream_data = '0;
      conf_in = '0;
      disp_in = '0;
      flush = 1'b0;
      pat5 = {16{16'h5555}};
      ones = '1;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_valid", 256'(xors_valid), 256'(0));
      check("rst_out",   xors_out,         256'(0));
      check("rst_conf",  256'(conf_out),   256'(0));
      check("rst_disp",  256'(disp_out),   256'(0));
      check("rst_count", 256'(blk_count),  256'(0));
      reset = 1'b1;
      @(negedge clk);
      check("rst_ready", 256'(pix_stream_ready), 256'(1));

      // One block of 2'b01 beats, downstream always ready
      rdy_mode = 3;
      rdy_man  = 1'b1;
      send_beats({128{2'b01}}, 8'h11, 8'h22, N, 0);
      idle(1);
      check("b1_valid", 256'(xors_valid), 256'(1));
      check("b1_out",   xors_out,         pat5);
      check("b1_conf",  256'(conf_out),   256'(8'h11));
      check("b1_disp",  256'(disp_out),   256'(8'h22));
      idle(1);
      check("b1_count", 256'(blk_count),  256'(1));
      check("b1_drop",  256'(xors_valid), 256'(0));

      // Two blocks with downstream stalled: A held, B waits in assembly
      do_reset();
      rdy_man = 1'b0;
      blk_a = rand_blk();
      blk_b = rand_blk();
      send_beats(blk_a, 8'hA1, 8'hA2, N, 0);
      send_beats(blk_b, 8'hB1, 8'hB2, N, 0);
      idle(1);
      check("bp_ready0", 256'(pix_stream_ready), 256'(0));
      check("bp_outA",   xors_out,               blk_a);
      check("bp_confA",  256'(conf_out),         256'(8'hA1));
      idle(3);
      check("bp_stableA", xors_out, blk_a);
      rdy_man = 1'b1;
      @(negedge clk);
      rdy_man = 1'b0;
      check("bp_outB",   xors_out,               blk_b);
      check("bp_dispB",  256'(disp_out),         256'(8'hB2));
      check("bp_ready1", 256'(pix_stream_ready), 256'(1));
      check("bp_count",  256'(blk_count),        256'(1));
      check("bp_valid",  256'(xors_valid),       256'(1));
      rdy_man = 1'b1;
      @(negedge clk);
      check("bp_count2", 256'(blk_count), 256'(2));

      // Flush mid-block, flushed cycle carries a beat that must be dropped
      do_reset();
      rdy_man = 1'b1;
      send_beats(rand_blk(), 8'h55, 8'h66, 64, 0);
      @(negedge clk);
      flush = 1'b1;
      pix_stream_valid = 1'b1;
      pix_stream_data = 2'b00;
      conf_in = 8'h77;
      disp_in = 8'h78;
      @(negedge clk);
      flush = 1'b0;
      pix_stream_valid = 1'b0;
      send_beats(ones, 8'h33, 8'h44, N, 10);
      idle(1);
      check("fl_valid", 256'(xors_valid), 256'(1));
      check("fl_out",   xors_out,         ones);
      check("fl_conf",  256'(conf_out),   256'(8'h33));
      check("fl_disp",  256'(disp_out),   256'(8'h44));
      check("fl_count", 256'(blk_count),  256'(0));
      idle(2);

      // Reset at beat 50 with a block sitting on the output
      rdy_man = 1'b0;
      blk_c = rand_blk();
      send_beats(blk_c, 8'hC1, 8'hC2, N, 0);
      send_beats(rand_blk(), 8'h01, 8'h02, 50, 0);
      @(negedge clk);
      reset = 1'b0;
      pix_stream_valid = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      pix_stream_valid = 1'b0;
      check("mr_valid", 256'(xors_valid),       256'(0));
      check("mr_out",   xors_out,               256'(0));
      check("mr_conf",  256'(conf_out),         256'(0));
      check("mr_count", 256'(blk_count),        256'(0));
      @(negedge clk);
      check("mr_ready", 256'(pix_stream_ready), 256'(1));
      rdy_man = 1'b1;
      blk_d = rand_blk();
      send_beats(blk_d, 8'hD1, 8'hD2, N, 20);
      idle(1);
      check("mr_outD",  xors_out,       blk_d);
      check("mr_confD", 256'(conf_out), 256'(8'hD1));
      idle(2);

      // blk_count wrap from 0xFFFF
      @(negedge clk);
      #2;
      force dut.blk_cnt_q = 16'hFFFF;
      #1;
      release dut.blk_cnt_q;
      preset_tok++;
      @(negedge clk);
      check("wr_pre", 256'(blk_count), 256'(16'hFFFF));
      send_beats(rand_blk(), 8'h10, 8'h20, N, 0);
      idle(2);
      check("wr_zero", 256'(blk_count), 256'(0));

      // Random input stalls and downstream back-pressure over 100 blocks
      do_reset();
      rdy_mode = 2;
      for (int b = 0; b < 100; b++) begin
         send_beats(rand_blk(), 8'($urandom), 8'($urandom), N, 30);
      end
      idle(1);
      rdy_mode = 3;
      rdy_man  = 1'b1;
      idle(5);
      check("rs_count", 256'(blk_count),  256'(100));
      check("rs_idle",  256'(xors_valid), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, finished=0 required 1");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/stream_to_xors.md
STREAM_TO_XORS -- requirements
Module: stream_to_xors

Interface
REQ-001 Parameter blk_w, default 16, block width in XOR bits.
REQ-002 Parameter blk_h, default 16, block height in XOR bits.
REQ-003 Parameter pix_w, default 2, bits per stream beat; blk_w*blk_h SHALL be a multiple of pix_w.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 pix_stream_data  input  pix_w  one beat of XOR bits, raster order within block.
REQ-007 pix_stream_valid  input  1  beat present this cycle.
REQ-008 pix_stream_ready  output  1  module accepts a beat this cycle.
REQ-009 conf_in  input  8  block confidence, sampled on the block's first beat.
REQ-010 disp_in  input  8  block disparity, sampled on the block's first beat.
REQ-011 flush  input  1  discard the partially assembled block.
REQ-012 xors_out  output  blk_h*blk_w  assembled block; bit j is row j/blk_w, column j%blk_w.
REQ-013 xors_valid  output  1  xors_out, conf_out, disp_out hold a complete block.
REQ-014 xors_ready  input  1  downstream accepts block when asserted with xors_valid.
REQ-015 conf_out  output  8  confidence of the block on xors_out.
REQ-016 disp_out  output  8  disparity of the block on xors_out.
REQ-017 blk_count  output  16  number of blocks accepted downstream, wraps modulo 2^16.

Function
REQ-018 A beat SHALL be accepted when pix_stream_valid && pix_stream_ready && !flush.
REQ-019 Beat k (0..N-1, N = blk_w*blk_h/pix_w) SHALL write pix_stream_data[b] to assembly bit k*pix_w+b.
REQ-020 The beat counter SHALL wrap to 0 after beat N-1 is accepted.
REQ-021 conf_in/disp_in SHALL be captured only when beat 0 is accepted; other beats SHALL ignore them.
REQ-022 Output register is "free" in a cycle when xors_valid==0 or xors_ready==1.
REQ-023 When beat N-1 is accepted and output register is free, the completed block (including that beat) SHALL load into xors_out/conf_out/disp_out at that edge; xors_valid=1 next cycle (latency 1 cycle).
REQ-024 When beat N-1 is accepted and output register not free, assembly SHALL hold the block and set asm_full=1.
REQ-025 pix_stream_ready SHALL equal !asm_full (combinational from registered state).
REQ-026 While asm_full=1, first cycle with xors_ready=1 SHALL load held block into output, clear asm_full; xors_valid stays 1.
REQ-027 xors_valid && !xors_ready SHALL hold xors_out, conf_out, disp_out stable.
REQ-028 Output accepted with no new block loading SHALL clear xors_valid next cycle.
REQ-029 blk_count SHALL increment by 1 on every cycle with xors_valid && xors_ready; 0xFFFF wraps to 0x0000.
REQ-030 flush SHALL zero the beat counter and clear asm_full; it SHALL NOT alter output register, xors_valid or blk_count.
REQ-031 flush with pix_stream_valid in the same cycle: beat SHALL be discarded.
REQ-032 Back-to-back blocks with xors_ready held 1 SHALL sustain one beat per cycle with no bubbles.

Reset
REQ-033 reset==0 at an edge SHALL set beat counter=0, asm_full=0, xors_valid=0, blk_count=0, xors_out=0, conf_out=0, disp_out=0.
REQ-034 pix_stream_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset mid-block or with asm_full=1 SHALL discard all partial and held data.

Verification
REQ-036 Default params, 128 beats of data 2'b01, conf_in=0x11/disp_in=0x22 on beat 0, xors_ready=1 -> xors_valid one cycle after beat 127, xors_out=all bits 0x5555... pattern, conf_out=0x11, disp_out=0x22, blk_count=1.
REQ-037 xors_ready=0, stream 2 full blocks (A then B) -> A held stable, pix_stream_ready=0 after B's last beat; raise xors_ready 1 cycle -> B appears next cycle, pix_stream_ready=1, blk_count=1.
REQ-038 64 beats then flush=1 with pix_stream_valid=1, then 128 beats of 2'b11 -> output block all ones, conf_out from post-flush beat 0.
REQ-039 Reset asserted at beat 50 -> all outputs zero next cycle, next block assembles from beat 0 correctly.
REQ-040 Preload blk_count to 0xFFFF via 65535 accepted blocks (or forced) then accept one more -> blk_count=0x0000.
REQ-041 Random valid/ready stalls over 100 blocks -> every block matches scoreboard bit-for-bit, no beat lost or duplicated.
